// File: rtl/di_ch_array.sv
// di_ch_array: parametrised digital-input channel array with debounce, edge counters and line test
module di_ch_array #(
    parameter int CH_NUM     = 32,
    parameter int CH_STRIDE  = 64,
    parameter int ADDR_W     = 12,
    parameter int TEST_INT   = 50000,
    parameter int TEST_PULSE = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_parwren,
    input  logic [ADDR_W-1:0]   im_paraddr,
    input  logic [7:0]          im_pardata,
    input  logic                i_rdren,
    input  logic [ADDR_W-1:0]   im_rdaddr,
    output logic [7:0]          om_rddata,
    input  logic [CH_NUM-1:0]   i_din,
    output logic [CH_NUM-1:0]   o_di_state,
    output logic [CH_NUM-1:0]   o_test_open,
    output logic [CH_NUM-1:0]   o_test_close,
    output logic [2*CH_NUM-1:0] led_ctrl
);
    localparam int OFF_W = $clog2(CH_STRIDE);
    localparam int CW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int TW    = $clog2(((TEST_INT > TEST_PULSE) ? TEST_INT : TEST_PULSE) + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_OPEN = 2'd1, S_CLOSE = 2'd2, S_RECOV = 2'd3;
    localparam logic [OFF_W-1:0] O_CFG    = OFF_W'(5'h00);
    localparam logic [OFF_W-1:0] O_FILT   = OFF_W'(5'h01);
    localparam logic [OFF_W-1:0] O_STATUS = OFF_W'(5'h10);
    localparam logic [OFF_W-1:0] O_EDGES  = OFF_W'(5'h11);
    localparam logic [OFF_W-1:0] O_FCLR   = OFF_W'(5'h12);

    logic [2:0]        r_cfg   [CH_NUM];
    logic [7:0]        r_filt  [CH_NUM];
    logic [7:0]        r_cnt   [CH_NUM];
    logic [7:0]        r_edges [CH_NUM];
    logic [CH_NUM-1:0] r_sync1, r_sync2, r_filtered, r_stuck, r_open;
    logic [1:0]        r_state;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_ptr, r_ch;
    logic [CH_NUM-1:0] w_s, w_test, w_flip, w_hit;
    logic [CW-1:0]     w_wi, w_ri, w_next;
    logic [OFF_W-1:0]  w_woff, w_roff;
    logic              w_wvalid, w_rvalid, w_found, w_last, w_abort, w_set_stuck, w_set_open;
    logic [7:0]        w_rd;
    int                w_j;

    assign w_wvalid     = i_parwren && (32'(im_paraddr >> OFF_W) < CH_NUM);
    assign w_wi         = CW'(im_paraddr >> OFF_W);
    assign w_woff       = im_paraddr[OFF_W-1:0];
    assign w_rvalid     = 32'(im_rdaddr >> OFF_W) < CH_NUM;
    assign w_ri         = CW'(im_rdaddr >> OFF_W);
    assign w_roff       = im_rdaddr[OFF_W-1:0];
    assign w_last       = r_timer == TW'(TEST_PULSE - 1);
    assign w_abort      = (r_state != S_IDLE) && w_wvalid && (w_wi == r_ch) && (w_woff == O_CFG) && !im_pardata[0];
    assign w_set_stuck  = (r_state == S_OPEN) && w_last && !w_abort && w_s[r_ch];
    assign w_set_open   = (r_state == S_CLOSE) && w_last && !w_abort && !w_s[r_ch];
    assign o_di_state   = r_filtered;
    assign o_test_open  = (r_state == S_OPEN) ? w_test : '0;
    assign o_test_close = (r_state == S_CLOSE) ? w_test : '0;
    assign w_rd = !w_rvalid ? 8'h00 :
                  (w_roff == O_CFG)    ? {5'd0, r_cfg[w_ri]} :
                  (w_roff == O_FILT)   ? r_filt[w_ri] :
                  (w_roff == O_STATUS) ? {3'd0, w_test[w_ri], r_open[w_ri], r_stuck[w_ri], w_s[w_ri], r_filtered[w_ri]} :
                  (w_roff == O_EDGES)  ? r_edges[w_ri] : 8'h00;

    // Per-channel sample after invert, test freeze, flip condition, write hit and LED code
    always_comb begin
        w_s      = '0;
        w_test   = '0;
        w_flip   = '0;
        w_hit    = '0;
        led_ctrl = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            w_s[i]    = r_sync2[i] ^ r_cfg[i][1];
            w_test[i] = (r_state != S_IDLE) && (int'(r_ch) == i);
            w_hit[i]  = w_wvalid && (int'(w_wi) == i);
            w_flip[i] = r_cfg[i][0] && !w_test[i] && (w_s[i] != r_filtered[i]) && (r_cnt[i] >= r_filt[i]);
            led_ctrl[2*i +: 2] = !r_cfg[i][0] ? 2'b00 : (r_stuck[i] || r_open[i]) ? 2'b11 : r_filtered[i] ? 2'b10 : 2'b01;
        end
    end

    // Round-robin pick: first channel at or after r_ptr with enable and test_en set
    always_comb begin
        w_found = 1'b0;
        w_next  = r_ptr;
        w_j     = 0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= CH_NUM) w_j = w_j - CH_NUM;
            if (r_cfg[w_j][0] && r_cfg[w_j][2]) begin
                w_found = 1'b1;
                w_next  = CW'(w_j);
            end
        end
    end

    // Per-channel synchroniser, config, debounce, edge counter and sticky faults
    always_ff @(posedge clk) begin
        r_sync1 <= rst ? '0 : i_din;
        r_sync2 <= rst ? '0 : r_sync1;
        for (int i = 0; i < CH_NUM; i++) begin
            if (rst) begin
                r_cfg[i]      <= '0;
                r_filt[i]     <= '0;
                r_cnt[i]      <= '0;
                r_edges[i]    <= '0;
                r_filtered[i] <= 1'b0;
                r_stuck[i]    <= 1'b0;
                r_open[i]     <= 1'b0;
            end else begin
                if (w_hit[i] && w_woff == O_CFG) r_cfg[i] <= im_pardata[2:0];
                if (w_hit[i] && w_woff == O_FILT) r_filt[i] <= im_pardata;
                r_edges[i] <= (w_hit[i] && w_woff == O_EDGES) ? 8'd0 : r_edges[i] + {7'd0, w_flip[i]};
                r_stuck[i] <= (w_set_stuck && w_test[i]) || (r_stuck[i] && !(w_hit[i] && w_woff == O_FCLR && im_pardata[2]));
                r_open[i]  <= (w_set_open && w_test[i]) || (r_open[i] && !(w_hit[i] && w_woff == O_FCLR && im_pardata[3]));
                if (!r_cfg[i][0]) begin
                    r_filtered[i] <= 1'b0;
                    r_cnt[i]      <= 8'd0;
                end else if (!w_test[i]) begin
                    r_filtered[i] <= w_flip[i] ? w_s[i] : r_filtered[i];
                    r_cnt[i]      <= (w_flip[i] || w_s[i] == r_filtered[i]) ? 8'd0 : r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Line-test sequencer: interval wait, then OPEN/CLOSE/RECOV on one channel
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            if (rst) begin
                r_ptr <= '0;
                r_ch  <= '0;
            end
        end else if (r_state == S_IDLE) begin
            r_timer <= (r_timer == TW'(TEST_INT - 1)) ? '0 : r_timer + TW'(1);
            if (r_timer == TW'(TEST_INT - 1) && w_found) begin
                r_state <= S_OPEN;
                r_ch    <= w_next;
            end
        end else if (w_last) begin
            r_state <= r_state + 2'd1;
            r_timer <= '0;
            if (r_state == S_RECOV) r_ptr <= (r_ch == CW'(CH_NUM - 1)) ? '0 : r_ch + CW'(1);
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Registered read port: updates only on a read strobe
    always_ff @(posedge clk) begin
        om_rddata <= rst ? 8'h00 : i_rdren ? w_rd : om_rddata;
    end
endmodule

// File: tb/tb_di_ch_array.sv
// tb_di_ch_array: directed self-checking bench for di_ch_array
module tb_di_ch_array;
    localparam int CH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_parwren, i_rdren;
    logic [11:0]   im_paraddr, im_rdaddr;
    logic [7:0]    im_pardata, om_rddata;
    logic [CH-1:0] i_din, din_base, loop_mask, o_di_state, o_test_open, o_test_close;
    logic [2*CH-1:0] led_ctrl;
    int            n_tests = 0;
    int            n_fail = 0;
    logic          found;
    int            ch, gap;

    // Line model: open drive pulls the input low, close drive pulls it high
    assign i_din = (din_base & ~(loop_mask & o_test_open)) | (loop_mask & o_test_close);

    di_ch_array #(.CH_NUM(32), .CH_STRIDE(64), .ADDR_W(12), .TEST_INT(100), .TEST_PULSE(10)) dut (
        .clk(clk), .rst(rst), .i_parwren(i_parwren), .im_paraddr(im_paraddr), .im_pardata(im_pardata),
        .i_rdren(i_rdren), .im_rdaddr(im_rdaddr), .om_rddata(om_rddata), .i_din(i_din),
        .o_di_state(o_di_state), .o_test_open(o_test_open), .o_test_close(o_test_close), .led_ctrl(led_ctrl)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int c, input int off, input logic [7:0] v);
        i_parwren = 1'b1; im_paraddr = 12'(c * 64 + off); im_pardata = v;
        @(negedge clk);
        i_parwren = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input int c, input int off, input logic [7:0] exp);
        i_rdren = 1'b1; im_rdaddr = 12'(c * 64 + off);
        @(negedge clk);
        i_rdren = 1'b0;
        chk(tag, om_rddata, exp);
    endtask

    task automatic wait_open(output logic f, output int c, output int n);
        f = 1'b0; c = -1; n = 0;
        while (!f && n < 400) begin
            @(negedge clk);
            n++;
            if (|o_test_open) begin
                f = 1'b1;
                for (int i = 0; i < CH; i++) if (o_test_open[i]) c = i;
            end
        end
    endtask

    task automatic observe(input string tag, input int exp_ch, output int n);
        logic f, frozen;
        int c;
        logic [CH-1:0] snap;
        wait_open(f, c, n);
        chk({tag, "_start"}, f, 1);
        chk({tag, "_ch"}, c, exp_ch);
        snap = o_di_state;
        frozen = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_di_state !== snap) frozen = 1'b0;
            if (k == 15) chk({tag, "_close"}, o_test_close, 64'(1) << exp_ch);
        end
        chk({tag, "_frozen"}, frozen, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_parwren = 1'b0; i_rdren = 1'b0; im_paraddr = '0; im_rdaddr = '0; im_pardata = '0;
        din_base = '1; loop_mask = '0;
        tick(3);
        chk("t1_state", o_di_state, 0);
        chk("t1_open", o_test_open, 0);
        chk("t1_close", o_test_close, 0);
        chk("t1_led", led_ctrl, 0);
        chk("t1_rddata", om_rddata, 0);
        rst = 1'b0; din_base = '0;
        chk_rd("t1_cfg", 5, 8'h00, 8'h00);
        chk_rd("t1_filt", 5, 8'h01, 8'h00);
        chk_rd("t1_status", 5, 8'h10, 8'h00);
        chk_rd("t1_edges", 5, 8'h11, 8'h00);

        wr(5, 8'h00, 8'h01);
        wr(5, 8'h01, 8'h04);
        din_base[5] = 1'b1;
        tick(6);
        chk("t2_before", o_di_state[5], 0);
        tick(1);
        chk("t2_rise", o_di_state[5], 1);
        chk("t2_led", led_ctrl[11:10], 2'b10);
        chk_rd("t2_edges", 5, 8'h11, 8'h01);
        din_base[5] = 1'b0;
        tick(3);
        din_base[5] = 1'b1;
        tick(10);
        chk("t2_glitch", o_di_state[5], 1);
        chk_rd("t2_edges_glitch", 5, 8'h11, 8'h01);
        chk_rd("t2_status", 5, 8'h10, 8'h03);
        wr(5, 8'h00, 8'h03);
        tick(10);
        chk("t2_invert", o_di_state[5], 0);
        chk_rd("t2_status_inv", 5, 8'h10, 8'h00);
        chk_rd("t2_edges_inv", 5, 8'h11, 8'h02);

        wr(0, 8'h00, 8'h01);
        for (int k = 0; k < 255; k++) begin
            din_base[0] = ~din_base[0];
            tick(2);
        end
        tick(5);
        chk_rd("t3_edges255", 0, 8'h11, 8'hFF);
        din_base[0] = ~din_base[0];
        tick(5);
        chk_rd("t3_wrap", 0, 8'h11, 8'h00);
        din_base[0] = ~din_base[0];
        tick(2);
        wr(0, 8'h11, 8'h5A);
        chk("t3_flip", o_di_state[0], 1);
        chk_rd("t3_clear_wins", 0, 8'h11, 8'h00);
        din_base[0] = ~din_base[0];
        tick(5);
        chk_rd("t3_after_clear", 0, 8'h11, 8'h01);
        i_parwren = 1'b1; im_paraddr = 12'h001; im_pardata = 8'h55;
        i_rdren = 1'b1; im_rdaddr = 12'h001;
        @(negedge clk);
        i_parwren = 1'b0; i_rdren = 1'b0;
        chk("t3_rw_old", om_rddata, 8'h00);
        chk_rd("t3_rw_new", 0, 8'h01, 8'h55);
        wr(0, 8'h05, 8'hAA);
        chk_rd("t3_unmapped", 0, 8'h05, 8'h00);
        wr(32, 8'h00, 8'h07);
        chk_rd("t3_bad_ch", 32, 8'h00, 8'h00);

        din_base[2] = 1'b1; din_base[7] = 1'b1;
        loop_mask[2] = 1'b1; loop_mask[7] = 1'b1;
        wr(2, 8'h00, 8'h05);
        wr(7, 8'h00, 8'h05);
        observe("t4_a", 2, gap);
        observe("t4_b", 7, gap);
        chk("t4_gap_b", gap, 100);
        observe("t4_c", 2, gap);
        chk("t4_gap_c", gap, 100);
        chk_rd("t4_status2", 2, 8'h10, 8'h03);
        chk_rd("t4_status7", 7, 8'h10, 8'h03);
        chk_rd("t4_edges2", 2, 8'h11, 8'h01);
        chk("t4_led2", led_ctrl[5:4], 2'b10);

        wr(2, 8'h00, 8'h01);
        wr(7, 8'h00, 8'h01);
        din_base[3] = 1'b1;
        wr(3, 8'h00, 8'h05);
        observe("t5_a", 3, gap);
        chk_rd("t5_stuck", 3, 8'h10, 8'h07);
        chk("t5_led_fault", led_ctrl[7:6], 2'b11);
        din_base[3] = 1'b0;
        observe("t5_b", 3, gap);
        chk_rd("t5_open", 3, 8'h10, 8'h0C);
        wr(3, 8'h12, 8'h04);
        chk_rd("t5_fclr_stuck", 3, 8'h10, 8'h08);
        wr(3, 8'h12, 8'h08);
        chk_rd("t5_fclr_open", 3, 8'h10, 8'h00);
        chk("t5_led_ok", led_ctrl[7:6], 2'b01);
        wait_open(found, ch, gap);
        chk("t5_c_start", found, 1);
        chk("t5_c_ch", ch, 3);
        tick(19);
        wr(3, 8'h12, 8'h08);
        chk_rd("t5_set_wins", 3, 8'h10, 8'h18);
        tick(10);

        wr(3, 8'h00, 8'h00);
        loop_mask[2] = 1'b0;
        wr(2, 8'h00, 8'h05);
        wait_open(found, ch, gap);
        chk("t6_a_start", found, 1);
        chk("t6_a_ch", ch, 2);
        tick(9);
        chk("t6_open_before", o_test_open, 64'h4);
        wr(2, 8'h00, 8'h00);
        chk("t6_open_abort", o_test_open, 0);
        chk("t6_close_abort", o_test_close, 0);
        tick(2);
        chk_rd("t6_no_fault", 2, 8'h10, 8'h02);
        chk("t6_led_off", led_ctrl[5:4], 2'b00);
        loop_mask[2] = 1'b1;
        wr(2, 8'h00, 8'h05);
        wait_open(found, ch, gap);
        chk("t6_b_start", found, 1);
        chk("t6_b_ch", ch, 2);
        tick(12);
        chk("t6_close_before", o_test_close, 64'h4);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_open", o_test_open, 0);
        chk("t6_rst_close", o_test_close, 0);
        chk("t6_rst_state", o_di_state, 0);
        chk("t6_rst_led", led_ctrl, 0);
        rst = 1'b0;
        tick(1);
        chk_rd("t6_rst_cfg", 2, 8'h00, 8'h00);
        wr(2, 8'h00, 8'h05);
        wait_open(found, ch, gap);
        chk("t6_c_start", found, 1);
        chk("t6_c_ch", ch, 2);
        tick(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
